video_pattern_gen: RTL and testbench

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

---
 rtl/video_timing_pkg.sv | 45 ++++
 rtl/video_timing_counter.sv | 70 +++++++
 rtl/video_pattern_gen.sv | 149 ++++++++++++++
 tb/tb_video_pattern_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared video timing defaults (720p), pattern-mode encoding and colour-bar palette.
package video_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 1280;
    localparam int unsigned DEF_H_FP     = 110;
    localparam int unsigned DEF_H_SYNC   = 40;
    localparam int unsigned DEF_H_BP     = 220;
    localparam int unsigned DEF_V_ACTIVE = 720;
    localparam int unsigned DEF_V_FP     = 5;
    localparam int unsigned DEF_V_SYNC   = 5;
    localparam int unsigned DEF_V_BP     = 20;

    typedef enum logic [1:0] {
        ModeBars    = 2'd0,
        ModeMagenta = 2'd1,
        ModeRamp    = 2'd2,
        ModeChecker = 2'd3
    } pattern_mode_e;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        c = BAR_BLACK;
        case (idx)
            3'd0: c = BAR_WHITE;
            3'd1: c = BAR_YELLOW;
            3'd2: c = BAR_CYAN;
            3'd3: c = BAR_GREEN;
            3'd4: c = BAR_MAGENTA;
            3'd5: c = BAR_RED;
            3'd6: c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster counters (hc, vc), active-region decode and unregistered sync generation.
module video_timing_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b1,
    parameter int unsigned HW       = 11,
    parameter int unsigned VW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] hc,
    output logic [VW-1:0] vc,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    always_comb begin
        hc_d = hc_q + HW'(1);
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + VW'(1);
        end
    end

    always_comb begin
        hc          = hc_q;
        vc          = vc_q;
        active      = (hc_q < H_ACT) && (vc_q < V_ACT);
        hsync       = ((hc_q >= HS_BEG) && (hc_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync       = ((vc_q >= VS_BEG) && (vc_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
        frame_start = (hc_q == '0) && (vc_q == '0);
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source with button-selected mode, switched only at frame start.
// Define PATTERN_GEN_SCROLL_EN to scroll modes 0/2/3 horizontally by one pixel per frame.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn,
    output logic [23:0] o_vid_data,
    output logic        o_vid_hsync,
    output logic        o_vid_vsync,
    output logic        o_vid_VDE
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic          active, hsync, vsync, frame_start;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .hc          (hc),
        .vc          (vc),
        .active      (active),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    logic [3:0] btn_s1_q, btn_s2_q, btn_s3_q, btn_rise;
    logic       unused_btn3;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            btn_s3_q <= '0;
        end else begin
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
        end
    end

    assign btn_rise    = btn_s2_q & ~btn_s3_q;
    assign unused_btn3 = btn_rise[3];

    pattern_mode_e pend_q, pend_d, act_q, act_d, mode_eff;

    always_comb begin
        pend_d = pend_q;
        if (btn_rise[2]) begin
            pend_d = ModeBars;
        end else if (btn_rise[0] && !btn_rise[1]) begin
            pend_d = pattern_mode_e'(pend_q + 2'd1);
        end else if (btn_rise[1] && !btn_rise[0]) begin
            pend_d = pattern_mode_e'(pend_q - 2'd1);
        end
    end

    // The first pixel of a frame already uses the newly loaded mode.
    assign act_d    = frame_start ? pend_q : act_q;
    assign mode_eff = act_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= ModeBars;
            act_q  <= ModeBars;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
        end
    end

    logic [31:0] px;

`ifdef PATTERN_GEN_SCROLL_EN
    logic [10:0] frame_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else if ((hc == HW'(H_TOTAL - 1)) && (vc == VW'(V_TOTAL - 1))) begin
            frame_q <= frame_q + 11'd1;
        end
    end

    assign px = (32'(hc) + 32'(frame_q)) % H_ACTIVE;
`else
    assign px = 32'(hc);
`endif

    logic        vc_b5;
    logic [23:0] pix;

    assign vc_b5 = |(32'(vc) & 32'h20);

    always_comb begin
        pix = BAR_BLACK;
        unique case (mode_eff)
            ModeBars:    pix = bar_colour(3'((px * 32'd8) / H_ACTIVE));
            ModeMagenta: pix = BAR_MAGENTA;
            ModeRamp:    pix = {3{8'((px * 32'd256) / H_ACTIVE)}};
            ModeChecker: pix = (px[5] ^ vc_b5) ? BAR_WHITE : BAR_BLACK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_vid_data  <= '0;
            o_vid_VDE   <= 1'b0;
            o_vid_hsync <= ~SYNC_POL;
            o_vid_vsync <= ~SYNC_POL;
        end else begin
            o_vid_data  <= active ? pix : 24'h000000;
            o_vid_VDE   <= active;
            o_vid_hsync <= hsync;
            o_vid_vsync <= vsync;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench: default 720p, a 64x40 mid-size raster for mode/reset tests and an 8x4 raster.
module tb_video_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_all, rst_med;
    logic [3:0] btn_med;
    logic [3:0] btn_idle;

    logic [23:0] d_data, m_data, s_data;
    logic        d_hs, d_vs, d_vde;
    logic        m_hs, m_vs, m_vde;
    logic        s_hs, s_vs, s_vde;

    video_pattern_gen u_def (
        .clk (clk), .rst (rst_all), .btn (btn_idle),
        .o_vid_data (d_data), .o_vid_hsync (d_hs), .o_vid_vsync (d_vs), .o_vid_VDE (d_vde)
    );

    video_pattern_gen #(
        .H_ACTIVE (64), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (40), .V_FP (1), .V_SYNC (1), .V_BP (1), .SYNC_POL (1'b1)
    ) u_med (
        .clk (clk), .rst (rst_med), .btn (btn_med),
        .o_vid_data (m_data), .o_vid_hsync (m_hs), .o_vid_vsync (m_vs), .o_vid_VDE (m_vde)
    );

    video_pattern_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1), .SYNC_POL (1'b1)
    ) u_sml (
        .clk (clk), .rst (rst_all), .btn (btn_idle),
        .o_vid_data (s_data), .o_vid_hsync (s_hs), .o_vid_vsync (s_vs), .o_vid_VDE (s_vde)
    );

    // After the edge that sets cnt to N, the outputs show raster pixel N-1.
    int cnt_all = 0;
    int cnt_med = 0;
    always @(posedge clk) cnt_all <= rst_all ? 0 : cnt_all + 1;
    always @(posedge clk) cnt_med <= rst_med ? 0 : cnt_med + 1;

    int n_vec = 0;
    int n_bad = 0;

    int s_vde_n = 0, s_hs_n = 0;
    int hs_r1 = -1, hs_r2 = -1, vs_r1 = -1, vs_r2 = -1;
    logic s_hs_prev = 1'b0, s_vs_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_all && cnt_all >= 1) begin
            if (cnt_all <= 98 && s_vde) s_vde_n <= s_vde_n + 1;
            if (cnt_all <= 14 && s_hs) s_hs_n <= s_hs_n + 1;
            if (s_hs && !s_hs_prev) begin
                if (hs_r1 < 0) hs_r1 <= cnt_all - 1;
                else if (hs_r2 < 0) hs_r2 <= cnt_all - 1;
            end
            if (s_vs && !s_vs_prev) begin
                if (vs_r1 < 0) vs_r1 <= cnt_all - 1;
                else if (vs_r2 < 0) vs_r2 <= cnt_all - 1;
            end
        end
        s_hs_prev <= s_hs;
        s_vs_prev <= s_vs;
    end

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_all(input int p);
        int n = 0;
        while (cnt_all != p + 1 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (cnt_all != p + 1) begin
            n_vec++;
            n_bad++;
            $error("FAIL wait_all observed=%0d expected=%0d", cnt_all, p + 1);
        end
    endtask

    task automatic wait_med(input int p);
        int n = 0;
        while (cnt_med != p + 1 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (cnt_med != p + 1) begin
            n_vec++;
            n_bad++;
            $error("FAIL wait_med observed=%0d expected=%0d", cnt_med, p + 1);
        end
    endtask

    task automatic press_med(input logic [3:0] mask);
        btn_med = mask;
        repeat (4) @(negedge clk);
        btn_med = 4'b0000;
    endtask

    initial begin
        rst_all  = 1'b1;
        rst_med  = 1'b1;
        btn_med  = 4'b0000;
        btn_idle = 4'b0000;

        @(negedge clk);
        @(negedge clk);
        check("rst_def_data", d_data, 24'h000000);
        check("rst_def_vde", {23'd0, d_vde}, 24'd0);
        check("rst_def_hs", {23'd0, d_hs}, 24'd0);
        check("rst_def_vs", {23'd0, d_vs}, 24'd0);
        @(negedge clk);
        rst_all = 1'b0;
        rst_med = 1'b0;

        // Default 720p, mode 0 bars on the first line
        wait_all(0);
        check("def_px0", d_data, 24'hFFFFFF);
        check("def_vde0", {23'd0, d_vde}, 24'd1);
        wait_med(7);
        check("med_px7_white", m_data, 24'hFFFFFF);
        wait_med(8);
        check("med_px8_yellow", m_data, 24'hFFFF00);
        wait_all(639);
        check("def_px639", d_data, 24'h00FF00);
        wait_all(640);
        check("def_px640", d_data, 24'hFF00FF);

        wait_med(1000);
        press_med(4'b0001);

        wait_all(1279);
        check("def_px1279", d_data, 24'h000000);
        check("def_vde1279", {23'd0, d_vde}, 24'd1);
        wait_all(1280);
        check("def_vde1280", {23'd0, d_vde}, 24'd0);
        wait_all(1389);
        check("def_hs1389", {23'd0, d_hs}, 24'd0);
        wait_all(1390);
        check("def_hs1390", {23'd0, d_hs}, 24'd1);
        wait_all(1430);
        check("def_hs1430", {23'd0, d_hs}, 24'd0);
        wait_all(1500);
        check("def_blank1500", d_data, 24'h000000);

        // Small raster measurements
        check("sml_hs_first", 24'(hs_r1), 24'd10);
        check("sml_hs_period", 24'(hs_r2 - hs_r1), 24'd14);
        check("sml_hs_high", 24'(s_hs_n), 24'd2);
        check("sml_vs_first", 24'(vs_r1), 24'd70);
        check("sml_vs_period", 24'(vs_r2 - vs_r1), 24'd98);
        check("sml_vde_frame", 24'(s_vde_n), 24'd32);

        // Frame 0 keeps mode 0 after the press; frame 1 is magenta
        wait_med(2000);
        check("med_f0_red", m_data, 24'hFF0000);
        wait_med(2738);
        check("med_f0_last_line", m_data, 24'hFFFF00);
        wait_med(2800);
        check("med_vblank_data", m_data, 24'h000000);
        check("med_vblank_vde", {23'd0, m_vde}, 24'd0);
        wait_med(3010);
        check("med_f1_px0", m_data, 24'hFF00FF);
        wait_med(3050);
        check("med_f1_px40", m_data, 24'hFF00FF);

        wait_med(4000);
        press_med(4'b0001);

        // Frames 2 and 3: grey ramp, 4 levels per pixel
        wait_med(6025);
`ifdef PATTERN_GEN_SCROLL_EN
        check("med_f2_ramp5", m_data, 24'h1C1C1C);
`else
        check("med_f2_ramp5", m_data, 24'h141414);
`endif
        wait_med(6083);
`ifdef PATTERN_GEN_SCROLL_EN
        check("med_f2_ramp63", m_data, 24'h040404);
`else
        check("med_f2_ramp63", m_data, 24'hFCFCFC);
`endif
        wait_med(9035);
`ifdef PATTERN_GEN_SCROLL_EN
        check("med_f3_ramp5", m_data, 24'h202020);
`else
        check("med_f3_ramp5", m_data, 24'h141414);
`endif

        wait_med(10000);
        press_med(4'b0001);

        // Frame 4: checkerboard
        wait_med(12042);
        check("med_f4_chk_blk", m_data, 24'h000000);
        wait_med(12080);
        check("med_f4_chk_wht", m_data, 24'hFFFFFF);

        wait_med(13000);
        press_med(4'b0101);

        wait_med(14352);
        check("med_f4_chk_vc33", m_data, 24'hFFFFFF);

        // Frame 5: btn2 beat btn0, back to bars
        wait_med(15050);
        check("med_f5_px0", m_data, 24'hFFFFFF);
        wait_med(15060);
        check("med_f5_px10", m_data, 24'hFFFF00);

        wait_med(16000);
        press_med(4'b0010);
        wait_med(16500);
        press_med(4'b1000);

        // Frame 6: btn1 wrapped 0 -> 3, btn3 ignored
        wait_med(18062);
        check("med_f6_chk_blk", m_data, 24'h000000);
        wait_med(18100);
        check("med_f6_chk_wht", m_data, 24'hFFFFFF);

        // Pending update lands in the frame-7 (0,0) cycle: frame 7 unchanged
        wait_med(21067);
        press_med(4'b0001);
        wait_med(21110);
        check("med_f7_still_chk", m_data, 24'hFFFFFF);
        wait_med(24120);
`ifdef PATTERN_GEN_SCROLL_EN
        check("med_f8_bars", m_data, 24'h0000FF);
`else
        check("med_f8_bars", m_data, 24'hFF0000);
`endif

        // Reset while the counter sits at hc=30, vc=20
        wait_med(25509);
`ifdef PATTERN_GEN_SCROLL_EN
        check("med_pre_rst", m_data, 24'hFF00FF);
`else
        check("med_pre_rst", m_data, 24'h00FF00);
`endif
        rst_med = 1'b1;
        @(negedge clk);
        check("med_rst_data", m_data, 24'h000000);
        check("med_rst_vde", {23'd0, m_vde}, 24'd0);
        check("med_rst_hs", {23'd0, m_hs}, 24'd0);
        check("med_rst_vs", {23'd0, m_vs}, 24'd0);
        @(negedge clk);
        rst_med = 1'b0;
        check("med_rel_vde_low", {23'd0, m_vde}, 24'd0);
        wait_med(0);
        check("med_rel_vde", {23'd0, m_vde}, 24'd1);
        check("med_rel_px0", m_data, 24'hFFFFFF);
        wait_med(65);
        check("med_rel_hs65", {23'd0, m_hs}, 24'd0);
        wait_med(66);
        check("med_rel_hs66", {23'd0, m_hs}, 24'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
